// File: rtl/decoder_onehot_seq.sv
// Registered N-to-2^N one-hot decoder with enable, pulse/hold modes,
// optional index-0 masking and a hardware sweep of every output.
module decoder_onehot_seq #(
  parameter int unsigned SEL_W     = 4,
  parameter bit          MASK_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  input  logic                  hold,
  input  logic                  sweep_start,
  output logic [(1<<SEL_W)-1:0] y,
  output logic                  y_valid,
  output logic                  busy,
  output logic                  sweep_done
);

  localparam int unsigned OUT_W     = 1 << SEL_W;
  localparam int unsigned CNT_W     = SEL_W + 1;
  localparam int unsigned START_IDX = MASK_ZERO ? 1 : 0;
  localparam int unsigned LAST_IDX  = OUT_W - 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             busy_q, busy_d;
  logic             sweep_done_q, sweep_done_d;

  // Next-state and next-output logic; busy/sweep_done default low every cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    y_d          = y_q;
    y_valid_d    = y_valid_q;
    busy_d       = 1'b0;
    sweep_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          y_d       = OUT_W'(1) << START_IDX;
          y_valid_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = CNT_W'(START_IDX + 1);
          // A one-output sweep finishes on its first output.
          if (START_IDX == LAST_IDX) begin
            sweep_done_d = 1'b1;
          end else begin
            state_d = ST_SWEEP;
          end
        end else if (en) begin
          if (MASK_ZERO && (sel == '0)) begin
            y_d       = '0;
            y_valid_d = 1'b0;
          end else begin
            y_d       = OUT_W'(1) << sel;
            y_valid_d = 1'b1;
          end
        end else if (!hold || busy_q) begin
          // busy_q here means the last output came from a sweep: never latch it.
          y_d       = '0;
          y_valid_d = 1'b0;
        end
      end

      ST_SWEEP: begin
        y_d       = OUT_W'(1) << cnt_q;
        y_valid_d = 1'b1;
        busy_d    = 1'b1;
        if (cnt_q == CNT_W'(LAST_IDX)) begin
          sweep_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      y_q          <= '0;
      y_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign y          = y_q;
  assign y_valid    = y_valid_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Directed bench for decoder_onehot_seq: a masked (MASK_ZERO=1) and an
// unmasked (MASK_ZERO=0) instance driven by the same stimulus.
module tb_decoder_onehot_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sel;
  logic        en, hold, sweep_start;
  logic [15:0] y1, y0;
  logic        v1, v0, busy1, busy0, done1, done0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_onehot_seq #(.SEL_W(4), .MASK_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .en(en), .hold(hold),
    .sweep_start(sweep_start), .y(y1), .y_valid(v1), .busy(busy1),
    .sweep_done(done1)
  );

  decoder_onehot_seq #(.SEL_W(4), .MASK_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .en(en), .hold(hold),
    .sweep_start(sweep_start), .y(y0), .y_valid(v0), .busy(busy0),
    .sweep_done(done0)
  );

  typedef struct {
    logic        en;
    logic        hold;
    logic [3:0]  sel;
    logic [15:0] y1;
    logic        v1;
    logic [15:0] y0;
    logic        v0;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Hand-computed decode / hold / masking sequence.
    vecs[0]  = '{1'b1, 1'b0, 4'd5,  16'h0020, 1'b1, 16'h0020, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 4'd5,  16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'd15, 16'h8000, 1'b1, 16'h8000, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 4'd2,  16'h8000, 1'b1, 16'h8000, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 4'd7,  16'h8000, 1'b1, 16'h8000, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 4'd0,  16'h8000, 1'b1, 16'h8000, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 4'd9,  16'h8000, 1'b1, 16'h8000, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 4'd1,  16'h8000, 1'b1, 16'h8000, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 4'd3,  16'h0008, 1'b1, 16'h0008, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 16'h0001, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 4'd0,  16'h0000, 1'b0, 16'h0001, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 4'd10, 16'h0400, 1'b1, 16'h0400, 1'b1};

    rst_n = 1'b0; sel = '0; en = 1'b0; hold = 1'b0; sweep_start = 1'b0;
    #12;
    chk("reset_y",     32'(y1),    32'h0);
    chk("reset_valid", 32'(v1),    32'h0);
    chk("reset_busy",  32'(busy1), 32'h0);
    chk("reset_done",  32'(done1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      en = vecs[i].en; hold = vecs[i].hold; sel = vecs[i].sel;
      step();
      chk($sformatf("vec%0d_y", i),      32'(y1),    32'(vecs[i].y1));
      chk($sformatf("vec%0d_valid", i),  32'(v1),    32'(vecs[i].v1));
      chk($sformatf("vec%0d_y_m0", i),   32'(y0),    32'(vecs[i].y0));
      chk($sformatf("vec%0d_vld_m0", i), 32'(v0),    32'(vecs[i].v0));
      chk($sformatf("vec%0d_busy", i),   32'(busy1), 32'h0);
    end

    // Sweep started together with a decode of 7: the decode is dropped.
    sweep_start = 1'b1; en = 1'b1; sel = 4'd7; hold = 1'b0;
    step();
    chk("sweep_first_y",    32'(y1),    32'h0002);
    chk("sweep_first_y_m0", 32'(y0),    32'h0001);
    chk("sweep_first_busy", 32'(busy1), 32'h1);
    sweep_start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k >= 15) begin
        en = 1'b0; hold = 1'b1; sel = 4'd3;
      end else begin
        en = k[0]; hold = k[1]; sel = 4'(k * 3);
      end
      step();
      if (k <= 14) begin
        chk($sformatf("sw%0d_y", k),    32'(y1),    32'(16'h1 << (k + 1)));
        chk($sformatf("sw%0d_busy", k), 32'(busy1), 32'h1);
        chk($sformatf("sw%0d_done", k), 32'(done1), 32'(k == 14));
      end else begin
        chk($sformatf("sw%0d_y_after", k),    32'(y1),    32'h0);
        chk($sformatf("sw%0d_vld_after", k),  32'(v1),    32'h0);
        chk($sformatf("sw%0d_busy_after", k), 32'(busy1), 32'h0);
        chk($sformatf("sw%0d_done_after", k), 32'(done1), 32'h0);
      end
      if (k <= 15) begin
        chk($sformatf("sw%0d_y_m0", k),    32'(y0),    32'(16'h1 << k));
        chk($sformatf("sw%0d_busy_m0", k), 32'(busy0), 32'h1);
        chk($sformatf("sw%0d_done_m0", k), 32'(done0), 32'(k == 15));
      end else begin
        chk("sw_after_y_m0",    32'(y0),    32'h0);
        chk("sw_after_busy_m0", 32'(busy0), 32'h0);
      end
    end

    // Back-to-back: sweep_start held across the return to IDLE.
    en = 1'b0; hold = 1'b0; sweep_start = 1'b1;
    step();
    chk("b2b_first", 32'(y1), 32'h0002);
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 15) chk("b2b_restart_y", 32'(y1), 32'h0002);
    end
    sweep_start = 1'b0;
    for (int k = 0; k < 16; k++) step();
    chk("b2b_idle_busy", 32'(busy1), 32'h0);

    // Abort mid-sweep with an asynchronous reset while y = 0x0040.
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("abort_pre_y", 32'(y1), 32'h0040);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_y",    32'(y1),    32'h0);
    chk("abort_vld",  32'(v1),    32'h0);
    chk("abort_busy", 32'(busy1), 32'h0);
    chk("abort_done", 32'(done1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("abort_idle%0d_done", k), 32'(done1), 32'h0);
    end
    en = 1'b1; sel = 4'd9; hold = 1'b0;
    step();
    chk("post_abort_y",   32'(y1), 32'h0200);
    chk("post_abort_vld", 32'(v1), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_onehot_seq.md
Name: decoder_onehot_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder.
- Successor to the fixed 4:16 combinational decoder in the datapath.
- Drives register-file write enables in the 32-bit RISC core.
- Adds enable, pulse/hold output modes, optional masking of index 0 (hard-wired zero register), and a hardware sweep mode that walks every output once so the register file can be cleared after reset.

Parameters:
- SEL_W, 4: select width; output width is 2^SEL_W.
- MASK_ZERO, 1: 1 = index 0 never asserted (decode or sweep); 0 = index 0 behaves like any other.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- sel, in, SEL_W: index to decode.
- en, in, 1: decode request, sampled each rising edge.
- hold, in, 1: output mode. 0 = pulse (output clears when en=0); 1 = latch (output keeps last decode).
- sweep_start, in, 1: request a full sweep of all outputs.
- y, out, 2^SEL_W: registered one-hot output, or all zeros.
- y_valid, out, 1: high when y carries a one-hot value.
- busy, out, 1: high while a sweep is in progress.
- sweep_done, out, 1: one-cycle pulse coincident with the final sweep output.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - y=0, y_valid=0, busy=0, sweep_done=0.
  - State IDLE, sweep counter 0.
  - Deassertion is synchronous to clk in the surrounding design.
- All outputs are registered. Latency from sampled input to output is 1 cycle.
- Two states: IDLE and SWEEP.
- IDLE, at each rising edge (priority order):
  1. sweep_start=1:
     - Go to SWEEP; en is ignored this edge.
     - y <= one-hot of the start index, y_valid=1, busy=1.
     - Start index = 1 if MASK_ZERO else 0.
     - Counter <= start index + 1.
  2. en=1, and sel is not 0 while MASK_ZERO=1:
     - y <= 1<<sel, y_valid <= 1.
  3. en=1, sel=0, MASK_ZERO=1:
     - y <= 0, y_valid <= 0. This is a masked decode, not an error.
  4. en=0, hold=0: y <= 0, y_valid <= 0.
  5. en=0, hold=1: y and y_valid keep their current values.
- SWEEP, at each rising edge:
  - en, sel, hold and sweep_start are ignored.
  - If counter < 2^SEL_W-1: y <= 1<<counter, y_valid=1, counter increments.
  - If counter == 2^SEL_W-1: y <= 1<<counter, y_valid=1, sweep_done <= 1, next state IDLE.
  - Counter width is SEL_W+1 internally; no wrap occurs before the terminal compare.
- Edge after the last sweep output:
  - State is IDLE, so normal IDLE rules apply to that edge's inputs.
  - busy <= 0, sweep_done <= 0.
  - If no en/sweep_start, y clears regardless of hold. Sweep contents are never latched.
- Sweep length:
  - busy is high for exactly 2^SEL_W - MASK_ZERO cycles.
  - Each non-masked output is asserted for exactly one cycle, in ascending order.
- sweep_start held high across the return to IDLE starts a new sweep on the next IDLE edge. Back-to-back sweeps are legal.
- Reset mid-sweep aborts immediately: no sweep_done, all outputs 0.
- Invariant: y is never multi-hot. y_valid == (y != 0).

Test Plan (SEL_W=4, MASK_ZERO=1 unless noted):
1. Reset and decode:
   - rst_n low then high; check y=0, y_valid=0.
   - en=1, hold=0, sel=5 for one cycle -> next cycle y=16'h0020, y_valid=1; the cycle after, y=0.
2. Hold mode:
   - hold=1, en=1, sel=15 one cycle, then en=0 for 5 cycles -> y=16'h8000 for all 5 cycles.
   - Then en=1, sel=3 -> y=16'h0008.
3. Masking:
   - en=1, sel=0 -> y=0, y_valid=0.
   - Repeat with MASK_ZERO=0 -> y=16'h0001, y_valid=1.
4. Sweep:
   - sweep_start one cycle -> busy high 15 cycles; y walks 16'h0002 through 16'h8000.
   - sweep_done high only with 16'h8000; en/sel toggled during the sweep have no effect.
   - With MASK_ZERO=0 -> 16 cycles starting at 16'h0001.
5. Simultaneous request: sweep_start=1 and en=1, sel=7 on the same edge -> sweep runs, first y=16'h0002, decode of 7 is dropped.
6. Reset mid-sweep: assert rst_n=0 while y=16'h0040 -> y=0, busy=0, with no clock edge needed; sweep_done never pulses.
   - After release, a decode with sel=9 -> y=16'h0200.
